// File: rtl/spi_slave_if.sv
// SPI pin bundle plus the transmit-buffer handshake and receive-byte outputs
// of the spi_slave front end.
interface spi_slave_if;
  logic       i_spi_sclk;
  logic       i_spi_cs_n;
  logic       i_spi_mosi;
  logic       o_spi_miso;
  logic       o_spi_miso_oe;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic       o_tx_underrun;
  logic       o_spi_s_rx_done;
  logic [7:0] r_spi_s_rx_data;

  modport slave (
    input  i_spi_sclk, i_spi_cs_n, i_spi_mosi, i_tx_data, i_tx_valid,
    output o_spi_miso, o_spi_miso_oe, o_tx_ready, o_tx_underrun,
           o_spi_s_rx_done, r_spi_s_rx_data
  );

  modport master (
    output i_spi_sclk, i_spi_cs_n, i_spi_mosi, i_tx_data, i_tx_valid,
    input  o_spi_miso, o_spi_miso_oe, o_tx_ready, o_tx_underrun,
           o_spi_s_rx_done, r_spi_s_rx_data
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples SCLK/CS_N/MOSI in the clk domain, assembles
// MSB-first bytes and shifts out one byte per transfer from a 1-entry buffer.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_TX     = 8'h00
) (
  input logic        clk,
  input logic        rst_n,
  spi_slave_if.slave bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_d1_q, cs_d1_q;
  logic                   started_q, cs_hi_seen_q;

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall;

  logic [0:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       done_q, done_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic       underrun_q, underrun_d;
  logic       oe_q;
  logic       load, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_d1_q    <= 1'b0;
      cs_d1_q      <= 1'b1;
      started_q    <= 1'b0;
      cs_hi_seen_q <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.i_spi_sclk};
        cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.i_spi_cs_n};
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.i_spi_mosi};
      end else begin
        sclk_sync_q <= bus.i_spi_sclk;
        cs_sync_q   <= bus.i_spi_cs_n;
        mosi_sync_q <= bus.i_spi_mosi;
      end
      sclk_d1_q    <= sclk_s;
      cs_d1_q      <= cs_s;
      started_q    <= 1'b1;
      cs_hi_seen_q <= cs_hi_seen_q | (started_q & cs_sync_q[0]);
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s & sclk_d1_q;
  // The synchroniser resets to CS_N high; if the pin was already low, flushing
  // those reset ones would fake a falling edge. Only honour a fall once a real
  // high level has been sampled from the pin since reset.
  assign cs_fall   = ~cs_s & cs_d1_q & cs_hi_seen_q;
  assign accept    = bus.i_tx_valid & ~buf_full_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    tx_shift_d = tx_shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    underrun_d = 1'b0;
    load       = 1'b0;

    if (cs_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      if (cs_fall) begin
        state_d   = ST_ACTIVE;
        bit_cnt_d = '0;
        load      = 1'b1;
      end
    end else begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[5:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_data_d = {rx_shift_q, mosi_s};
          done_d    = 1'b1;
        end
      end
      if (sclk_fall) begin
        if (bit_cnt_q != 3'd0) tx_shift_d = {tx_shift_q[6:0], 1'b0};
        else                   load       = 1'b1;
      end
    end

    // Load sees the pre-accept buffer state, so a same-cycle accept is kept
    // for the following load.
    if (load) begin
      tx_shift_d = buf_full_q ? buf_q : IDLE_TX;
      underrun_d = ~buf_full_q;
      if (buf_full_q) buf_full_d = 1'b0;
    end
    if (accept) begin
      buf_d      = bus.i_tx_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
      tx_shift_q <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      underrun_q <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      tx_shift_q <= tx_shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      underrun_q <= underrun_d;
      oe_q       <= ~cs_s;
    end
  end

  assign bus.o_spi_miso      = oe_q & tx_shift_q[7];
  assign bus.o_spi_miso_oe   = oe_q;
  assign bus.o_tx_ready      = ~buf_full_q;
  assign bus.o_tx_underrun   = underrun_q;
  assign bus.o_spi_s_rx_done = done_q;
  assign bus.r_spi_s_rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model drives the pins at about
// 2 MHz and received bytes, MISO bytes and pulses are compared to fixed values.
module tb_spi_slave;

  localparam int HALF = 12;  // SCLK half period in clk cycles (~2 MHz)

  logic clk;
  logic rst_n;
  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(2), .IDLE_TX(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] rx_log[$];
  int         underruns = 0;
  logic [7:0] miso_cap[3];
  int         last_lat;

  always @(negedge clk) begin
    if (bus.o_spi_s_rx_done) rx_log.push_back(bus.r_spi_s_rx_data);
    if (bus.o_tx_underrun)   underruns++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, input bit track, output logic m, output int lat);
    bus.i_spi_mosi = b;
    wait_clks(HALF);
    bus.i_spi_sclk = 1'b1;
    m   = bus.o_spi_miso;
    lat = -1;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk);
      if (track && lat < 0 && bus.o_spi_s_rx_done) lat = i;
    end
    bus.i_spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    int   l;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], i == 0, m, l);
      rx[i] = m;
      if (i == 0) last_lat = l;
    end
  endtask

  task automatic spi_frame(input logic [7:0] b0, b1, b2, input int n);
    logic [7:0] r;
    bus.i_spi_cs_n = 1'b0;
    if (n > 0) begin spi_byte(b0, r); miso_cap[0] = r; end
    if (n > 1) begin spi_byte(b1, r); miso_cap[1] = r; end
    if (n > 2) begin spi_byte(b2, r); miso_cap[2] = r; end
    wait_clks(HALF);
    bus.i_spi_cs_n = 1'b1;
    wait_clks(HALF);
  endtask

  initial begin
    int         base;
    logic       m;
    int         l;
    logic [7:0] r;

    rst_n          = 1'b0;
    bus.i_tx_data  = 8'h00;
    bus.i_tx_valid = 1'b0;
    bus.i_spi_sclk = 1'b0;
    bus.i_spi_cs_n = 1'b1;
    bus.i_spi_mosi = 1'b0;

    // Reset with random pin activity
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.i_spi_sclk = 1'($urandom_range(0, 1));
      bus.i_spi_cs_n = 1'($urandom_range(0, 1));
      bus.i_spi_mosi = 1'($urandom_range(0, 1));
    end
    check("rst_miso",     32'(bus.o_spi_miso),      32'h0);
    check("rst_oe",       32'(bus.o_spi_miso_oe),   32'h0);
    check("rst_ready",    32'(bus.o_tx_ready),      32'h1);
    check("rst_underrun", 32'(bus.o_tx_underrun),   32'h0);
    check("rst_done",     32'(bus.o_spi_s_rx_done), 32'h0);
    check("rst_rxdata",   32'(bus.r_spi_s_rx_data), 32'h0);
    bus.i_spi_sclk = 1'b0;
    bus.i_spi_cs_n = 1'b1;
    bus.i_spi_mosi = 1'b0;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(HALF);
    check("rst_no_done", 32'(rx_log.size()), 32'd0);

    // Single byte; done expected SYNC_STAGES+1 negedges after the 8th rise drive
    spi_frame(8'hA5, 8'h00, 8'h00, 1);
    check("single_count", 32'(rx_log.size()), 32'd1);
    check("single_data",  32'(rx_log[0]), 32'hA5);
    check("single_lat",   32'(last_lat), 32'd3);
    check("single_reg",   32'(bus.r_spi_s_rx_data), 32'hA5);

    // Multi-byte frame
    base = rx_log.size();
    spi_frame(8'h3C, 8'hFF, 8'h00, 3);
    check("multi_count", 32'(rx_log.size() - base), 32'd3);
    check("multi_b0", 32'(rx_log[base]),   32'h3C);
    check("multi_b1", 32'(rx_log[base+1]), 32'hFF);
    check("multi_b2", 32'(rx_log[base+2]), 32'h00);

    // Transmit echo: preload C3, then two bytes on one CS_N
    bus.i_tx_data  = 8'hC3;
    bus.i_tx_valid = 1'b1;
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
    check("tx_full_ready", 32'(bus.o_tx_ready), 32'h0);
    underruns = 0;
    bus.i_spi_cs_n = 1'b0;
    wait_clks(6);
    check("tx_ready_after_load", 32'(bus.o_tx_ready), 32'h1);
    check("tx_no_underrun_load", 32'(underruns), 32'd0);
    spi_byte(8'h11, r);
    check("tx_miso_b0", 32'(r), 32'hC3);
    spi_byte(8'h22, r);
    check("tx_miso_b1", 32'(r), 32'h00);
    check("tx_underrun_count", 32'(underruns), 32'd1);
    wait_clks(HALF);
    bus.i_spi_cs_n = 1'b1;
    wait_clks(HALF);
    check("tx_rx_reg", 32'(bus.r_spi_s_rx_data), 32'h22);

    // Aborted byte after 5 SCLK rises
    base = rx_log.size();
    bus.i_spi_cs_n = 1'b0;
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, m, l);
    wait_clks(HALF);
    bus.i_spi_cs_n = 1'b1;
    wait_clks(HALF);
    check("abort_no_done", 32'(rx_log.size() - base), 32'd0);
    check("abort_reg_kept", 32'(bus.r_spi_s_rx_data), 32'h22);
    spi_frame(8'h81, 8'h00, 8'h00, 1);
    check("abort_next_count", 32'(rx_log.size() - base), 32'd1);
    check("abort_next_data", 32'(bus.r_spi_s_rx_data), 32'h81);

    // Reset after 3 bits with CS_N held low
    base = rx_log.size();
    bus.i_spi_cs_n = 1'b0;
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, m, l);
    rst_n = 1'b0;
    wait_clks(3);
    check("mrst_rxdata", 32'(bus.r_spi_s_rx_data), 32'h0);
    check("mrst_oe",     32'(bus.o_spi_miso_oe),   32'h0);
    check("mrst_ready",  32'(bus.o_tx_ready),      32'h1);
    rst_n = 1'b1;
    wait_clks(5);
    for (int i = 0; i < 8; i++) spi_bit(1'b1, 1'b0, m, l);
    wait_clks(HALF);
    check("mrst_ignored", 32'(rx_log.size() - base), 32'd0);
    check("mrst_ignored_reg", 32'(bus.r_spi_s_rx_data), 32'h0);
    bus.i_spi_cs_n = 1'b1;
    wait_clks(HALF);
    spi_frame(8'h5A, 8'h00, 8'h00, 1);
    check("mrst_next_count", 32'(rx_log.size() - base), 32'd1);
    check("mrst_next_data", 32'(bus.r_spi_s_rx_data), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 slave front end that feeds the LED blink block: it oversamples SCLK, CS_N and MOSI in the 50 MHz `clk` domain and assembles MSB-first bytes. Each completed byte is presented on `r_spi_s_rx_data` with a one-cycle `o_spi_s_rx_done` strobe. It also shifts out one byte per transfer on MISO from a single-entry transmit buffer loaded through a valid/ready handshake. Supported frames are multi-byte frames under a single CS_N assertion.

## Interface
- `SYNC_STAGES`, default 2: flops in each input synchroniser (legal range 2..3).
- `IDLE_TX`, default 8'h00: byte shifted out when the transmit buffer is empty at byte start.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `i_spi_sclk` in 1: SPI clock from master, asynchronous to `clk`.
- `i_spi_cs_n` in 1: chip select, active-low, asynchronous.
- `i_spi_mosi` in 1: master-out data, asynchronous.
- `o_spi_miso` out 1: slave-out data, MSB first.
- `o_spi_miso_oe` out 1: MISO output enable; 1 while selected.
- `i_tx_data` in 8: byte to transmit.
- `i_tx_valid` in 1: `i_tx_data` valid.
- `o_tx_ready` out 1: transmit buffer empty; accepts on valid&&ready.
- `o_tx_underrun` out 1: one-cycle pulse when `IDLE_TX` is loaded at byte start.
- `o_spi_s_rx_done` out 1: one-cycle pulse, new byte on `r_spi_s_rx_data`.
- `r_spi_s_rx_data` out 8: last complete received byte, held until next done.

## Operation
- **Synchronisers:** SCLK, CS_N and MOSI each pass through `SYNC_STAGES` flops.
  - Reset values: SCLK 0, CS_N 1, MOSI 0.
  - One further flop on synced SCLK and CS_N provides edge detection: `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`.
- **State machine:** IDLE and ACTIVE.
  - IDLE→ACTIVE on `cs_fall`. In that cycle: `bit_cnt`=0, tx shift register loaded (see TX load), MISO = shift[7].
  - ACTIVE→IDLE on `cs_rise`. Any partial byte (`bit_cnt`≠0) is discarded: no done, `r_spi_s_rx_data` unchanged, `bit_cnt`=0.
  - Synced CS_N high forces IDLE regardless of SCLK activity; SCLK edges in IDLE are ignored.
- **Receive:** on `sclk_rise` in ACTIVE:
  - rx_shift <= {rx_shift[6:0], mosi_sync}; `bit_cnt` increments mod 8.
  - When `bit_cnt`==7: `r_spi_s_rx_data` <= {rx_shift[6:0], mosi_sync}, `o_spi_s_rx_done` <= 1 for exactly one cycle, `bit_cnt` wraps to 0.
  - No backpressure: the next byte overwrites `r_spi_s_rx_data` unconditionally.
- **Transmit:** on `sclk_fall` in ACTIVE:
  - If `bit_cnt`≠0: tx shift left one; MISO = new shift[7].
  - If `bit_cnt`==0 (byte boundary after the 8th rise): TX load for the next byte.
- **TX load** occurs at `cs_fall` and at each byte boundary:
  - Buffer full: shift <= buffer, buffer marked empty (`o_tx_ready` rises next cycle).
  - Buffer empty: shift <= `IDLE_TX`, `o_tx_underrun` pulses one cycle.
- **TX buffer:** accepts `i_tx_data` when `i_tx_valid`&&`o_tx_ready`.
  - Accept and load in the same cycle: load takes the old (empty) state, so `IDLE_TX` is sent, and the accepted byte stays in the buffer for the next load.
- **Output enable:** `o_spi_miso_oe` = ~cs_n_sync (registered); `o_spi_miso` = 0 when not enabled.
- **Reset values:**
  - `o_spi_miso` 0, `o_spi_miso_oe` 0, `o_tx_ready` 1, `o_tx_underrun` 0, `o_spi_s_rx_done` 0, `r_spi_s_rx_data` 8'h00.
  - Internal: state IDLE, `bit_cnt` 0, buffer empty.
- **Reset mid-transfer:** all state returns to reset values immediately. After `rst_n` deasserts with CS_N already low, no `cs_fall` is seen, so the block stays IDLE until CS_N cycles high→low.

## Timing
- Let k be the first `clk` edge that samples the 8th SCLK rise high. `o_spi_s_rx_done` is high during the cycle after edge k+`SYNC_STAGES`, and `r_spi_s_rx_data` is valid from that cycle.
- Master constraints:
  - SCLK high and low phases each ≥ `SYNC_STAGES`+2 clk periods; SCLK ≤ 6.25 MHz at 50 MHz `clk` with `SYNC_STAGES`=2.
  - CS_N fall to first SCLK rise ≥ `SYNC_STAGES`+3 clk periods.
  - Last SCLK fall to CS_N rise ≥ `SYNC_STAGES`+2 clk periods.
- MISO changes `SYNC_STAGES`+1 clk cycles after the SCLK fall at the pin, and is stable before the next SCLK rise under the constraints above.
- `o_tx_ready` returns to 1 one cycle after a TX load consumes the buffer.

## Test plan
- **Reset:** `rst_n`=0 with random SPI pins -> all outputs at reset values, `o_tx_ready`=1, no done pulse.
- **Single-byte receive:** one frame, MOSI 8'hA5 at 2 MHz -> exactly one `o_spi_s_rx_done` pulse, `r_spi_s_rx_data`=8'hA5, latency per Timing.
- **Multi-byte frame:** 8'h3C, 8'hFF, 8'h00 under one CS_N -> three done pulses in order with those values.
- **Transmit echo:** preload 8'hC3, master sends two bytes -> MISO returns 8'hC3 then `IDLE_TX` 8'h00; one `o_tx_underrun` pulse at the second byte; `o_tx_ready` high after the first load.
- **Aborted byte:** CS_N rises after 5 SCLK edges -> no done, `r_spi_s_rx_data` keeps its prior value; the next full frame 8'h81 is received correctly.
- **Mid-frame reset:** assert `rst_n` after 3 bits with CS_N held low -> outputs reset; SCLK ignored until CS_N toggles; then byte 8'h5A received correctly.
